// File: rtl/switch_egress_arb.sv
// switch_egress_arb: round-robin drain of the switch output FIFOs onto one
// valid/ready egress bus, in bursts of up to MAX_BURST words per grant.
//
// Ports:
//   clk         - single clock, rising edge
//   rst_n       - synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   arb_en      - arbitration enable; 0 blocks new grants and burst continuation
//   port_ready  - per-port FIFO non-empty flags
//   port_out    - per-port FIFO heads, valid the cycle after port_read[i]
//   port_read   - one-cycle pop strobe, one-hot or zero (registered)
//   eg_valid    - egress word valid (registered)
//   eg_data     - egress word (registered)
//   eg_port     - source port of eg_data (registered)
//   eg_ready    - downstream accept
//   busy        - a grant is in progress (registered)
module switch_egress_arb #(
    parameter int unsigned  NUM_OF_PORTS = 4,
    parameter int unsigned  WORD_WIDTH   = 8,
    parameter int unsigned  MAX_BURST    = 4,
    localparam int unsigned PW           = $clog2(NUM_OF_PORTS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   arb_en,
    input  logic [NUM_OF_PORTS-1:0]                port_ready,
    input  logic [NUM_OF_PORTS-1:0][WORD_WIDTH-1:0] port_out,
    output logic [NUM_OF_PORTS-1:0]                port_read,
    output logic                                   eg_valid,
    output logic [WORD_WIDTH-1:0]                  eg_data,
    output logic [PW-1:0]                          eg_port,
    input  logic                                   eg_ready,
    output logic                                   busy
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CAPT = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           g_q, g_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_OF_PORTS-1:0] rd_q, rd_d;
    logic                    vld_q, vld_d;
    logic [WORD_WIDTH-1:0]   data_q, data_d;
    logic [PW-1:0]           port_q, port_d;
    logic                    busy_q, busy_d;

    logic [2*NUM_OF_PORTS-1:0] dbl_c;
    logic [NUM_OF_PORTS-1:0]   rot_c;
    logic [PW-1:0]             off_c;
    logic                      found_c;
    logic [PW-1:0]             pick_c;
    logic [PW-1:0]             g_inc_c;

    // Round-robin scan: rotate requests so bit 0 is ptr, take the lowest set bit.
    always_comb begin
        found_c = 1'b0;
        off_c   = '0;
        dbl_c   = {port_ready, port_ready} >> ptr_q;
        rot_c   = dbl_c[NUM_OF_PORTS-1:0];
        for (int i = NUM_OF_PORTS - 1; i >= 0; i--) begin
            if (rot_c[i]) begin
                found_c = 1'b1;
                off_c   = PW'(i);
            end
        end
        pick_c = PW'((32'(ptr_q) + 32'(off_c)) % NUM_OF_PORTS);
    end

    // Pointer value that skips past the current grant, wrapping at the last port.
    assign g_inc_c = (g_q == PW'(NUM_OF_PORTS - 1)) ? '0 : g_q + PW'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        rd_d    = '0;
        vld_d   = vld_q;
        data_d  = data_q;
        port_d  = port_q;

        case (state_q)
            IDLE: begin
                if (arb_en && found_c) begin
                    g_d     = pick_c;
                    cnt_d   = '0;
                    rd_d    = NUM_OF_PORTS'(1) << pick_c;
                    state_d = READ;
                end
            end
            READ: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = CAPT;
            end
            CAPT: begin
                data_d  = port_out[g_q];
                port_d  = g_q;
                vld_d   = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (eg_ready) begin
                    vld_d = 1'b0;
                    if ((cnt_q < CW'(MAX_BURST)) && port_ready[g_q] && arb_en) begin
                        rd_d    = NUM_OF_PORTS'(1) << g_q;
                        state_d = READ;
                    end else begin
                        // Early exits (port drained, arb_en low) still rotate past g.
                        ptr_d   = g_inc_c;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; rst_n is an active-high synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            port_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            port_q  <= port_d;
            busy_q  <= busy_d;
        end
    end

    assign port_read = rd_q;
    assign eg_valid  = vld_q;
    assign eg_data   = data_q;
    assign eg_port   = port_q;
    assign busy      = busy_q;

endmodule

// File: doc/switch_egress_arb.md
# switch_egress_arb

Round-robin egress arbiter that drains the per-port output FIFOs of the switch onto one shared egress bus. It watches each port's `port_ready` and pops words with `port_read`. Each popped word is presented on a valid/ready egress interface, tagged with its source port index. Grants are fair bursts of up to MAX_BURST words, and the grant pointer rotates after every burst.

## Interface
- NUM_OF_PORTS, 4, number of switch output ports arbitrated (2..16)
- WORD_WIDTH, 8, data word width in bits
- MAX_BURST, 4, maximum words popped per grant (1..255)
- PW (local), $clog2(NUM_OF_PORTS), width of the port index
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  one clock; reset is synchronous and active-high (rst_n = 1 resets)
- arb_en  input  1  arbitration enable; 0 means no new grants
- port_ready  input  [NUM_OF_PORTS]  port i FIFO holds at least one word
- port_out  input  [NUM_OF_PORTS] x WORD_WIDTH  port i FIFO head; valid the cycle after `port_read[i]`
- port_read  output  [NUM_OF_PORTS]  one-cycle pop strobe per port, one-hot or zero
- eg_valid  output  1  egress word valid
- eg_data  output  WORD_WIDTH  egress word
- eg_port  output  PW  source port of `eg_data`
- eg_ready  input  1  downstream accepts the word when `eg_valid` and `eg_ready` are both 1
- busy  output  1  a grant is active (state is not IDLE)

## Operation
- States: IDLE, READ, CAPT, SEND.
- IDLE:
  - If arb_en=1 and any port_ready=1, grant the first ready port found scanning ptr, ptr+1, … with wrap modulo NUM_OF_PORTS.
  - Latch the grant index g, clear burst_cnt, go to READ.
- READ: drive port_read[g]=1 for exactly this cycle, burst_cnt += 1, go to CAPT.
- CAPT: register port_out[g] into eg_data and g into eg_port, set eg_valid=1, go to SEND.
- SEND: hold eg_valid, eg_data and eg_port stable until eg_ready=1. On the handshake, clear eg_valid, then:
  - if burst_cnt < MAX_BURST, port_ready[g]=1 and arb_en=1 (sampled in the handshake cycle): go to READ;
  - otherwise: ptr ← (g+1) mod NUM_OF_PORTS, go to IDLE.
- ptr wraps from NUM_OF_PORTS-1 to 0. A port that leaves the burst early still advances ptr past g.
- arb_en=0 never aborts a word in flight. The current word completes its SEND handshake, then the block returns to IDLE.
- port_ready[g] dropping during READ or CAPT has no effect; the pop already issued is completed.
- Only one port_read bit is ever high, and only in READ.
- burst_cnt is an 8-bit counter, compared against MAX_BURST and cleared on grant.

## Timing
- Reset values: state=IDLE, ptr=0, g=0, burst_cnt=0, port_read=0, eg_valid=0, eg_data=0, eg_port=0, busy=0.
- Reset asserted in any state returns to the reset values on the next edge. A captured, unsent word is discarded.
- Request seen in IDLE at cycle T:
  - port_read[g]=1 at T+1;
  - eg_valid=1 at T+3.
- Back-to-back words in a burst:
  - handshake at cycle S;
  - next port_read at S+1;
  - next eg_valid at S+3.
- Without backpressure, throughput is 1 word per 3 cycles.
- After the burst-ending handshake at S, the block is in IDLE at S+1. The next grant's port_read is at S+2.
- busy=1 from the READ cycle through the final SEND handshake cycle inclusive.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Single port, MAX_BURST=4:
  - stimulus: port 2 holds 2 words (0xA1, 0xA2), eg_ready=1;
  - required: port_read[2] pulses twice, egress shows 0xA1 then 0xA2 with eg_port=2, block returns to IDLE, ptr=3.
- All four ports continuously ready, MAX_BURST=2:
  - required: grant order is 0,0,1,1,2,2,3,3,0,…;
  - required: exactly one port_read bit high per READ cycle.
- Wrap-around:
  - stimulus: ptr=3, only ports 1 and 3 ready;
  - required: port 3 is served first, then port 1; ptr=2 after port 1's burst.
- Backpressure:
  - stimulus: eg_ready=0 for 5 cycles after eg_valid rises;
  - required: eg_data and eg_port stable, no further port_read until the handshake, next port_read exactly 1 cycle after it.
- arb_en dropped during CAPT of word 1 of a 4-word burst:
  - required: word 1 is delivered, the block returns to IDLE, no further port_read while arb_en=0.
- rst_n=1 during SEND with eg_valid=1:
  - required: next cycle eg_valid=0, busy=0, ptr=0, all port_read=0; a fresh grant starts from port 0.
